serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial N-bit subtractor that computes minuend − subtrahend − borrow_in one bit per clock, LSB first, using a single registered full-subtractor borrow stage. It is the inverse arithmetic block of the combinational adder path and is intended for area-constrained datapaths where a WIDTH-cycle latency is acceptable. It uses a start/busy/done handshake, so a controlling FSM can launch an operation and collect the registered result.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits (≥ 2)

Ports:
- sys_clk  input  1  system clock, all state updates on rising edge
- sys_rst  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- minuend  input  WIDTH  operand A, sampled on the accepting edge
- subtrahend  input  WIDTH  operand B, sampled on the accepting edge
- borrow_in  input  1  initial borrow, sampled on the accepting edge
- busy  output  1  high while in BUSY
- done  output  1  single-cycle pulse when the result becomes valid
- difference  output  WIDTH  registered A − B − borrow_in (mod 2^WIDTH)
- borrow_out  output  1  final borrow: 1 when A < B + borrow_in (unsigned)
- overflow  output  1  signed overflow of the subtraction

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if start = 1, latch minuend to shift register a_sr, subtrahend to b_sr, borrow_in to borrow register br, clear bit counter cnt, and go to BUSY. Otherwise stay in IDLE.
- BUSY, on each edge, using a0 = a_sr[0], b0 = b_sr[0]:
  - d = a0 ^ b0 ^ br
  - br ← (~a0 & b0) | (~(a0 ^ b0) & br)
  - shift d into d_sr from the MSB side; shift a_sr and b_sr right by 1; cnt ← cnt + 1
- On the edge where cnt = WIDTH−1 (the last bit):
  - load difference from the final d_sr value, including this bit
  - borrow_out ← new br value
  - overflow ← (A_msb ≠ B_msb) & (diff_msb ≠ A_msb), using the latched operand MSBs held in a separate register
  - go to DONE
- DONE: done = 1 for exactly one cycle, then go to IDLE unconditionally.
- start is ignored in BUSY and DONE; there is no queuing, and the operands in flight are unaffected.
- Operand inputs are don't-care except on the accepting edge.
- difference, borrow_out and overflow hold their values until the next operation's final edge; they never show partial results.
- cnt width is clog2(WIDTH), and cnt never wraps during an operation.

## Timing
- Reset, asynchronous: state = IDLE, busy = 0, done = 0, difference = 0, borrow_out = 0, overflow = 0, and all internal shift registers, cnt and br cleared.
- Reset mid-operation aborts immediately. No done pulse is produced, and the outputs read 0.
- busy is a decode of state == BUSY. It rises on the edge that accepts start and is high for exactly WIDTH cycles.
- Latency: start accepted at edge k, result registered at edge k+WIDTH, done high during the cycle after edge k+WIDTH.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accept is the first edge after DONE.
- start held high continuously gives back-to-back operations at the WIDTH+2 cadence.
- done and busy are never high in the same cycle.

## Test plan
- Basic subtraction, WIDTH=8: A=0x5A, B=0x23, bin=0 → difference=0x37, borrow_out=0, overflow=0. done occurs 8 edges after the accepting edge, and busy is high for 8 cycles.
- Negative result: A=0x10, B=0x20, bin=0 → difference=0xF0, borrow_out=1, overflow=0.
- Borrow chain: A=0x00, B=0x00, bin=1 → difference=0xFF, borrow_out=1. Then A=0xFF, B=0xFF, bin=0 → difference=0x00, borrow_out=0.
- Signed overflow: A=0x80, B=0x01 → difference=0x7F, borrow_out=0, overflow=1. A=0x7F, B=0xFF → difference=0x80, borrow_out=1, overflow=1.
- Handshake:
  - Start A=0x33, B=0x11, then pulse start with A=0x00, B=0x01 during BUSY and again during DONE → single done, difference=0x22, no second operation.
  - start held high → done pulses every 10 cycles.
- Reset mid-op: assert sys_rst asynchronously at BUSY bit 4 of A=0x5A, B=0x23 → busy, done, difference, borrow_out and overflow go to 0 immediately. After release, a new op with A=0x09, B=0x03 → difference=0x06.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: minuend - subtrahend - borrow_in, LSB first, one bit per clock.
// Start/busy/done handshake; outputs update only on the final bit edge.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, d_sr;
  logic [WIDTH-1:0] d_nxt;
  logic [CW-1:0]    cnt;
  logic             br, br_nxt;
  logic             a_msb, b_msb;
  logic             a0, b0, d_bit;
  logic             last_bit;

  assign a0       = a_sr[0];
  assign b0       = b_sr[0];
  assign d_bit    = a0 ^ b0 ^ br;
  assign br_nxt   = (~a0 & b0) | (~(a0 ^ b0) & br);
  assign d_nxt    = {d_bit, d_sr[WIDTH-1:1]};
  assign last_bit = (state == BUSY) && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      BUSY:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      d_sr       <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      difference <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= minuend;
            b_sr  <= subtrahend;
            br    <= borrow_in;
            cnt   <= '0;
            a_msb <= minuend[WIDTH-1];
            b_msb <= subtrahend[WIDTH-1];
          end
        end
        BUSY: begin
          d_sr <= d_nxt;
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= br_nxt;
          if (last_bit) begin
            // d_bit is the result MSB on this edge
            difference <= d_nxt;
            borrow_out <= br_nxt;
            overflow   <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): vector table plus handshake,
// back-to-back and mid-operation reset sequences.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] minuend, subtrahend;
  logic         borrow_in;
  logic         busy, done, borrow_out, overflow;
  logic [W-1:0] difference;

  int n_cmp = 0;
  int n_err = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .start      (start),
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .difference (difference),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one operation and wait for done; reports edges to done and busy cycles.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; minuend = a; subtrahend = b; borrow_in = bin;
    @(posedge clk); #1;
    start = 1'b0;
    minuend = W'($urandom); subtrahend = W'($urandom); borrow_in = 1'($urandom);
    lat = 0; busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy && done) check("busy_done_overlap", 1, 0);
  endtask

  initial begin
    int lat, bcnt, ndone, nbusy, last_t, t;
    int dones[$];

    vecs[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0};
    vecs[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};
    vecs[8] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; minuend = '0; subtrahend = '0; borrow_in = 1'b0;
    #23;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_diff", 32'(difference), 0);
    check("rst_bo", 32'(borrow_out), 0);
    check("rst_ov", 32'(overflow), 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat, bcnt);
      check($sformatf("v%0d_latency", i), 32'(lat), W);
      check($sformatf("v%0d_busy_cycles", i), 32'(bcnt), W);
      check($sformatf("v%0d_diff", i), 32'(difference), 32'(vecs[i].d));
      check($sformatf("v%0d_bo", i), 32'(borrow_out), 32'(vecs[i].bo));
      check($sformatf("v%0d_ov", i), 32'(overflow), 32'(vecs[i].ov));
      @(posedge clk); #1;
      check($sformatf("v%0d_done_single", i), 32'(done), 0);
    end

    // start pulses during BUSY and during DONE must be ignored
    @(negedge clk);
    start = 1'b1; minuend = 8'h33; subtrahend = 8'h11; borrow_in = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); start = 1'b1; minuend = 8'h00; subtrahend = 8'h01;
    @(negedge clk); start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
    check("hs_done_seen", 32'(done), 1);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("hs_diff", 32'(difference), 32'h22);
    ndone = 0; nbusy = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
      if (busy) nbusy++;
    end
    check("hs_no_second_done", 32'(ndone), 0);
    check("hs_no_second_busy", 32'(nbusy), 0);
    check("hs_diff_held", 32'(difference), 32'h22);

    // start held high: back-to-back at WIDTH+2 cadence
    @(negedge clk);
    start = 1'b1; minuend = 8'h09; subtrahend = 8'h03; borrow_in = 1'b0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      if (done) dones.push_back(c);
      if (busy && done) check("b2b_overlap", 1, 0);
    end
    start = 1'b0;
    check("b2b_pulse_count", 32'(dones.size()), 4);
    for (int i = 1; i < dones.size(); i++)
      check($sformatf("b2b_period_%0d", i), 32'(dones[i] - dones[i-1]), W + 2);
    check("b2b_diff", 32'(difference), 32'h06);
    lat = 0;
    while ((busy || done) && lat < 20) begin @(posedge clk); #1; lat++; end
    check("b2b_drained", 32'(busy || done), 0);

    // mid-operation reset, after loading nonzero outputs
    run_op(8'h7F, 8'hFF, 1'b0, lat, bcnt);
    check("pre_rst_diff", 32'(difference), 32'h80);
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b1; minuend = 8'h5A; subtrahend = 8'h23; borrow_in = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_diff", 32'(difference), 0);
    check("mid_rst_bo", 32'(borrow_out), 0);
    check("mid_rst_ov", 32'(overflow), 0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    check("mid_rst_no_done", 32'(ndone), 0);
    run_op(8'h09, 8'h03, 1'b0, lat, bcnt);
    check("post_rst_latency", 32'(lat), W);
    check("post_rst_diff", 32'(difference), 32'h06);
    check("post_rst_bo", 32'(borrow_out), 0);

    last_t = 0; t = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
